// File: rtl/mp_req_master.sv
// -----------------------------------------------------------------------------
// mp_req_master
//
// Request master for a four-core multiprocessor memory/ALU unit. Each core has
// a one-entry holding slot. A round-robin arbiter presents one full slot at a
// time on the request bus. Issued core tags are remembered in a 4-deep tag FIFO
// so that responses can be checked for order. Responses are steered back to
// the core named by the response tag as a registered one-cycle pulse.
//
// Optional feature (macro MP_REQ_TIMEOUT_EN): a response watchdog. When no
// response arrives for TIMEOUT cycles while tags are outstanding, it sets the
// sticky timeout_err flag and flushes the tag FIFO. Without the macro there is
// no watchdog and timeout_err is tied low.
//
// Parameters: AW address width, DW data width, TIMEOUT watchdog limit (cycles).
//
// Ports:
//   clk, rst_n           clock (rising edge), asynchronous active-low reset
//   c_valid/c_ready      per-core request handshake (c_ready = slot empty)
//   c_opcode/c_addr/c_a/c_b/c_we   per-core request fields, packed by core
//   req, core_id, opcode, addr, A, B, we   request to the DUT (combinational)
//   gnt                  DUT accepts the presented request this cycle
//   rvalid, data_out, core_id_out   DUT response and its tag
//   rsp_valid/rsp_data   per-core registered response pulse and data lane
//   busy                 any slot full or any tag outstanding
//   order_err            sticky: response with empty FIFO or wrong tag
//   timeout_err          sticky: watchdog expired (macro builds only)
// -----------------------------------------------------------------------------
module mp_req_master #(
    parameter int AW      = 11,
    parameter int DW      = 8,
    parameter int TIMEOUT = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [3:0]      c_valid,
    output logic [3:0]      c_ready,
    input  logic [15:0]     c_opcode,
    input  logic [4*AW-1:0] c_addr,
    input  logic [4*DW-1:0] c_a,
    input  logic [4*DW-1:0] c_b,
    input  logic [3:0]      c_we,
    output logic            req,
    output logic [1:0]      core_id,
    output logic [3:0]      opcode,
    output logic [AW-1:0]   addr,
    output logic [DW-1:0]   A,
    output logic [DW-1:0]   B,
    output logic            we,
    input  logic            gnt,
    input  logic            rvalid,
    input  logic [DW-1:0]   data_out,
    input  logic [1:0]      core_id_out,
    output logic [3:0]      rsp_valid,
    output logic [4*DW-1:0] rsp_data,
    output logic            busy,
    output logic            order_err,
    output logic            timeout_err
);

    // Holding slots
    logic [3:0]    slot_full_reg;
    logic [3:0]    slot_op_reg   [4];
    logic [AW-1:0] slot_addr_reg [4];
    logic [DW-1:0] slot_a_reg    [4];
    logic [DW-1:0] slot_b_reg    [4];
    logic [3:0]    slot_we_reg;

    // Arbiter
    logic [1:0] rr_ptr_reg;
    logic [1:0] sel_idx;
    logic       sel_found;
    logic [1:0] cand_idx;
    logic       issue;

    // Tag FIFO
    logic [1:0] tag_mem_reg [4];
    logic [1:0] wr_ptr_reg;
    logic [1:0] rd_ptr_reg;
    logic [2:0] count_reg;
    logic       fifo_full;
    logic       fifo_empty;
    logic       push;
    logic       pop;
    logic       tmo_flush;

    // Response side
    logic [3:0]      rsp_valid_reg;
    logic [4*DW-1:0] rsp_data_reg;
    logic            order_err_reg;

    assign fifo_full  = (count_reg == 3'd4);
    assign fifo_empty = (count_reg == 3'd0);

    // Round-robin pick: first full slot scanning upward from rr_ptr, wrapping.
    always_comb begin
        sel_idx   = 2'd0;
        sel_found = 1'b0;
        cand_idx  = 2'd0;
        for (int k = 0; k < 4; k++) begin
            cand_idx = rr_ptr_reg + 2'(k);
            if (!sel_found && slot_full_reg[cand_idx]) begin
                sel_found = 1'b1;
                sel_idx   = cand_idx;
            end
        end
    end

    // Gated by the full flag as registered; a pop this cycle does not open room.
    assign req     = sel_found && !fifo_full;
    assign core_id = sel_idx;
    assign opcode  = slot_op_reg[sel_idx];
    assign addr    = slot_addr_reg[sel_idx];
    assign A       = slot_a_reg[sel_idx];
    assign B       = slot_b_reg[sel_idx];
    assign we      = slot_we_reg[sel_idx];
    assign issue   = req && gnt;
    assign push    = issue;
    assign pop     = rvalid && !fifo_empty;

    // Per-core slots. The slot being issued is full, so c_ready is low for it
    // and a capture can never coincide with its clear.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_slot
            assign c_ready[gi] = !slot_full_reg[gi];

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    slot_full_reg[gi] <= 1'b0;
                    slot_op_reg[gi]   <= '0;
                    slot_addr_reg[gi] <= '0;
                    slot_a_reg[gi]    <= '0;
                    slot_b_reg[gi]    <= '0;
                    slot_we_reg[gi]   <= 1'b0;
                end else if (issue && (sel_idx == 2'(gi))) begin
                    slot_full_reg[gi] <= 1'b0;
                end else if (c_valid[gi] && !slot_full_reg[gi]) begin
                    slot_full_reg[gi] <= 1'b1;
                    slot_op_reg[gi]   <= c_opcode[4*gi +: 4];
                    slot_addr_reg[gi] <= c_addr[AW*gi +: AW];
                    slot_a_reg[gi]    <= c_a[DW*gi +: DW];
                    slot_b_reg[gi]    <= c_b[DW*gi +: DW];
                    slot_we_reg[gi]   <= c_we[gi];
                end
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_reg <= 2'd0;
        end else if (issue) begin
            rr_ptr_reg <= sel_idx + 2'd1;
        end
    end

    // Tag FIFO. A flush drops everything queued before this edge; a push in
    // the same cycle still lands as the sole entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= 2'd0;
            rd_ptr_reg <= 2'd0;
            count_reg  <= 3'd0;
            for (int k = 0; k < 4; k++) begin
                tag_mem_reg[k] <= 2'd0;
            end
        end else begin
            if (push) begin
                tag_mem_reg[wr_ptr_reg] <= sel_idx;
                wr_ptr_reg              <= wr_ptr_reg + 2'd1;
            end
            if (tmo_flush) begin
                rd_ptr_reg <= wr_ptr_reg;
            end else if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + 2'd1;
            end
            count_reg <= (tmo_flush ? 3'd0 : (count_reg - 3'(pop))) + 3'(push);
        end
    end

    // Responses are routed by their own tag even when the order check fails.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid_reg <= 4'd0;
            rsp_data_reg  <= '0;
            order_err_reg <= 1'b0;
        end else begin
            rsp_valid_reg <= 4'd0;
            rsp_data_reg  <= '0;
            if (rvalid) begin
                rsp_valid_reg[core_id_out]          <= 1'b1;
                rsp_data_reg[DW*core_id_out +: DW]  <= data_out;
                if (fifo_empty || (tag_mem_reg[rd_ptr_reg] != core_id_out)) begin
                    order_err_reg <= 1'b1;
                end
            end
        end
    end

`ifdef MP_REQ_TIMEOUT_EN
    localparam int TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

    logic [TW-1:0] tmo_cnt_reg;
    logic          timeout_err_reg;
    logic          tmo_hit;

    // Counter is reset by any response or an idle FIFO; reaching TIMEOUT
    // counts means TIMEOUT consecutive silent cycles with tags outstanding.
    assign tmo_hit   = (tmo_cnt_reg == TW'(TIMEOUT - 1));
    assign tmo_flush = !rvalid && !fifo_empty && tmo_hit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_cnt_reg     <= '0;
            timeout_err_reg <= 1'b0;
        end else if (rvalid || fifo_empty) begin
            tmo_cnt_reg <= '0;
        end else if (tmo_hit) begin
            tmo_cnt_reg     <= '0;
            timeout_err_reg <= 1'b1;
        end else begin
            tmo_cnt_reg <= tmo_cnt_reg + TW'(1);
        end
    end

    assign timeout_err = timeout_err_reg;
`else
    assign tmo_flush   = 1'b0;
    assign timeout_err = 1'b0;
`endif

    assign rsp_valid = rsp_valid_reg;
    assign rsp_data  = rsp_data_reg;
    assign order_err = order_err_reg;
    assign busy      = (|slot_full_reg) || !fifo_empty;

endmodule

// File: tb/tb_mp_req_master.sv
// -----------------------------------------------------------------------------
// tb_mp_req_master
//
// Directed bench for mp_req_master. A small responder models the
// multiprocessor unit: it latches each granted request and answers with
// rvalid two cycles later (add, store, load, default xor). Specific tests
// switch the responder off and drive rvalid by hand to exercise tag order,
// FIFO-full gating, the timeout path and reset behaviour.
// -----------------------------------------------------------------------------
module tb_mp_req_master;
    localparam int AW = 11;
    localparam int DW = 8;
    localparam int TIMEOUT = 16;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [3:0]      c_valid;
    logic [3:0]      c_ready;
    logic [15:0]     c_opcode;
    logic [4*AW-1:0] c_addr;
    logic [4*DW-1:0] c_a;
    logic [4*DW-1:0] c_b;
    logic [3:0]      c_we;
    logic            req;
    logic [1:0]      core_id;
    logic [3:0]      opcode;
    logic [AW-1:0]   addr;
    logic [DW-1:0]   A;
    logic [DW-1:0]   B;
    logic            we;
    logic            gnt;
    logic            rvalid;
    logic [DW-1:0]   data_out;
    logic [1:0]      core_id_out;
    logic [3:0]      rsp_valid;
    logic [4*DW-1:0] rsp_data;
    logic            busy;
    logic            order_err;
    logic            timeout_err;

    int checks   = 0;
    int failures = 0;

    // Responder model state
    logic          resp_en;
    logic          m_rvalid, s1_v, s2_v, s3_v;
    logic [DW-1:0] m_data, s1_d, s2_d, s3_d;
    logic [1:0]    m_id, s1_id, s2_id, s3_id;
    logic [DW-1:0] mem [0:(1<<AW)-1];

    // Hand-forced response
    logic          f_rvalid;
    logic [1:0]    f_id;
    logic [DW-1:0] f_data;

    assign rvalid      = m_rvalid | f_rvalid;
    assign data_out    = f_rvalid ? f_data : m_data;
    assign core_id_out = f_rvalid ? f_id : m_id;

    always #5 clk = ~clk;

    mp_req_master #(.AW(AW), .DW(DW), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst_n(rst_n),
        .c_valid(c_valid), .c_ready(c_ready), .c_opcode(c_opcode),
        .c_addr(c_addr), .c_a(c_a), .c_b(c_b), .c_we(c_we),
        .req(req), .core_id(core_id), .opcode(opcode), .addr(addr),
        .A(A), .B(B), .we(we), .gnt(gnt),
        .rvalid(rvalid), .data_out(data_out), .core_id_out(core_id_out),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .busy(busy),
        .order_err(order_err), .timeout_err(timeout_err)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end else begin
            $display("ok   %s = %0h", tag, got);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_core(input int i, input logic [3:0] op, input logic [AW-1:0] ad,
                            input logic [DW-1:0] a, input logic [DW-1:0] b, input logic w);
        c_opcode[4*i +: 4] = op;
        c_addr[AW*i +: AW] = ad;
        c_a[DW*i +: DW]    = a;
        c_b[DW*i +: DW]    = b;
        c_we[i]            = w;
    endtask

    task automatic force_rsp(input logic [1:0] id, input logic [DW-1:0] d);
        f_rvalid = 1'b1;
        f_id     = id;
        f_data   = d;
        step();
        f_rvalid = 1'b0;
    endtask

    // Responder: grant seen before edge T launches rvalid after edge T+2,
    // so the master samples it at T+3.
    initial begin
        m_rvalid = 0; m_data = 0; m_id = 0;
        s1_v = 0; s2_v = 0; s3_v = 0;
        s1_d = 0; s2_d = 0; s3_d = 0;
        s1_id = 0; s2_id = 0; s3_id = 0;
        forever begin
            @(negedge clk);
            m_rvalid = s3_v; m_data = s3_d; m_id = s3_id;
            s3_v = s2_v; s3_d = s2_d; s3_id = s2_id;
            s2_v = s1_v; s2_d = s1_d; s2_id = s1_id;
            s1_v  = resp_en && rst_n && req && gnt;
            s1_id = core_id;
            s1_d  = '0;
            if (s1_v) begin
                case (opcode)
                    4'b0001: s1_d = A + B;
                    4'b0110: begin
                        if (we) mem[addr] = A;
                        s1_d = A;
                    end
                    4'b0101: s1_d = mem[addr];
                    default: s1_d = A ^ B;
                endcase
            end
        end
    end

    int rr_order [4] = '{2, 3, 0, 1};

    initial begin
        rst_n = 0; c_valid = 0; c_opcode = 0; c_addr = 0; c_a = 0; c_b = 0; c_we = 0;
        gnt = 0; f_rvalid = 0; f_id = 0; f_data = 0; resp_en = 1;
        repeat (2) step();

        // Reset state
        check("rst_c_ready", c_ready, 4'hf);
        check("rst_req", req, 0);
        check("rst_busy", busy, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_order_err", order_err, 0);
        check("rst_timeout_err", timeout_err, 0);
        rst_n = 1; gnt = 1;
        step();

        // Single add from core 2: 5 + 3
        set_core(2, 4'b0001, 11'h0, 8'd5, 8'd3, 1'b0);
        c_valid = 4'b0100;
        step();
        c_valid = 0;
        check("add_req", req, 1);
        check("add_core_id", core_id, 2);
        check("add_opcode", opcode, 1);
        check("add_A", A, 5);
        check("add_B", B, 3);
        check("add_c_ready_hold", c_ready, 4'b1011);
        step();                                  // issue edge T
        check("add_req_drop", req, 0);
        check("add_c_ready_free", c_ready, 4'hf);
        check("add_busy", busy, 1);
        step();
        check("add_rsp_t1", rsp_valid, 0);
        step();
        check("add_rsp_t2", rsp_valid, 0);
        step();
        check("add_rsp_t3", rsp_valid, 4'b0100);
        check("add_rsp_data", rsp_data, 32'h0008_0000);
        step();
        check("add_rsp_pulse", rsp_valid, 0);
        check("add_busy_idle", busy, 0);

        // Four simultaneous requests straight after reset
        rst_n = 0; step(); rst_n = 1; step();
        for (int i = 0; i < 4; i++) set_core(i, 4'b0001, 11'h0, 8'(i + 1), 8'd16, 1'b0);
        c_valid = 4'hf;
        step();
        c_valid = 0;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("rr4_req%0d", i), req, 1);
            check($sformatf("rr4_id%0d", i), core_id, i);
            step();
        end
        for (int j = 0; j < 4; j++) begin
            logic [4*DW-1:0] exp_d;
            exp_d = '0;
            exp_d[DW*j +: DW] = 8'(17 + j);
            check($sformatf("rr4_rsp%0d", j), rsp_valid, 4'b0001 << j);
            check($sformatf("rr4_data%0d", j), rsp_data, exp_d);
            step();
        end
        check("rr4_busy_idle", busy, 0);

        // Store then load on core 1
        set_core(1, 4'b0110, 11'h10, 8'hAA, 8'h00, 1'b1);
        c_valid = 4'b0010;
        step();
        c_valid = 0;
        step();                                  // store issued
        check("st_ready_next", c_ready[1], 1);
        set_core(1, 4'b0101, 11'h10, 8'h00, 8'h00, 1'b0);
        c_valid = 4'b0010;
        step();
        c_valid = 0;
        step();                                  // load issued
        step();
        check("st_rsp", rsp_valid, 4'b0010);
        check("st_data", rsp_data, 32'h0000_AA00);
        step();
        check("st_gap", rsp_valid, 0);
        step();
        check("ld_rsp", rsp_valid, 4'b0010);
        check("ld_data", rsp_data, 32'h0000_AA00);
        check("ld_order_err", order_err, 0);

        // Fill the tag FIFO (rr_ptr now 2, so order wraps 2,3,0,1)
        resp_en = 0;
        step();
        c_valid = 4'hf;
        step();
        c_valid = 0;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("full_id%0d", i), core_id, rr_order[i]);
            step();
        end
        c_valid = 4'b0001;
        step();
        c_valid = 0;
        check("full_req_gated", req, 0);
        check("full_busy", busy, 1);
        force_rsp(2'd2, 8'h11);                  // pop with full flag still set: no issue
        check("full_pop_rsp", rsp_valid, 4'b0100);
        check("full_no_issue", c_ready, 4'b1110);
        check("full_req_open", req, 1);
        force_rsp(2'd3, 8'h22);                  // pop and push together
        check("pp_issued", c_ready, 4'hf);
        check("pp_busy", busy, 1);
        force_rsp(2'd0, 8'h33);
        force_rsp(2'd1, 8'h44);
        force_rsp(2'd0, 8'h55);
        check("pp_order_err", order_err, 0);
        check("pp_busy_idle", busy, 0);

        // Wrong response tag
        set_core(1, 4'b0001, 11'h0, 8'd1, 8'd1, 1'b0);
        c_valid = 4'b0010;
        step();
        c_valid = 0;
        step();
        force_rsp(2'd3, 8'h5A);
        check("tag_rsp_lane", rsp_valid, 4'b1000);
        check("tag_rsp_data", rsp_data, 32'h5A00_0000);
        check("tag_order_err", order_err, 1);
        check("tag_busy", busy, 0);
        step();
        check("tag_order_sticky", order_err, 1);
        check("tag_rsp_pulse", rsp_valid, 0);

        // No response after issue
        c_valid = 4'b0010;
        step();
        c_valid = 0;
        step();                                  // issued
        repeat (15) step();
        check("tmo_before", timeout_err, 0);
        check("tmo_busy_before", busy, 1);
        step();
`ifdef MP_REQ_TIMEOUT_EN
        check("tmo_err", timeout_err, 1);
        check("tmo_busy", busy, 0);
        repeat (4) step();
        check("tmo_sticky", timeout_err, 1);
`else
        check("tmo_err", timeout_err, 0);
        check("tmo_busy", busy, 1);
        repeat (4) step();
        check("tmo_still_busy", busy, 1);
`endif

        // Reset with two responses outstanding and a held request
        c_valid = 4'b1001;
        step();
        c_valid = 0;
        step();
        step();
        gnt = 0;
        c_valid = 4'b0100;
        step();
        c_valid = 0;
        check("pre_rst_busy", busy, 1);
        check("pre_rst_ready", c_ready, 4'b1011);
        #2 rst_n = 0;
        #1;
        check("arst_c_ready", c_ready, 4'hf);
        check("arst_req", req, 0);
        check("arst_busy", busy, 0);
        check("arst_rsp_valid", rsp_valid, 0);
        check("arst_rsp_data", rsp_data, 0);
        check("arst_order_err", order_err, 0);
        check("arst_timeout_err", timeout_err, 0);
        step();
        rst_n = 1;
        gnt = 1;
        step();

        // Stray response with an empty FIFO
        force_rsp(2'd0, 8'h77);
        check("empty_order_err", order_err, 1);
        check("empty_rsp", rsp_valid, 4'b0001);
        check("empty_data", rsp_data, 32'h0000_0077);
        check("empty_busy", busy, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mp_req_master.md
MP_REQ_MASTER -- requirements
Module: mp_req_master

Interface
REQ-001 SHALL have parameters: AW, default 11, memory address width; DW, default 8, data width; TIMEOUT, default 16, response timeout in cycles.
REQ-002 SHALL have the following ports, one per line as name, direction, width, meaning:
- clk  in  1  clock, all state on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- c_valid  in  4  per-core request valid.
- c_ready  out  4  per-core holding slot empty.
- c_opcode  in  16  per-core opcode; core i uses bits [4i+3:4i].
- c_addr  in  4*AW  per-core address.
- c_a  in  4*DW  per-core operand A.
- c_b  in  4*DW  per-core operand B.
- c_we  in  4  per-core write enable.
- req  out  1  request valid to the multiprocessor DUT.
- core_id  out  2  issuing core.
- opcode  out  4  issued opcode.
- addr  out  AW  issued address.
- A  out  DW  issued operand A.
- B  out  DW  issued operand B.
- we  out  1  issued write enable.
- gnt  in  1  grant from the DUT.
- rvalid  in  1  DUT response valid.
- data_out  in  DW  DUT result.
- core_id_out  in  2  DUT response tag.
- rsp_valid  out  4  per-core response pulse.
- rsp_data  out  4*DW  per-core response data.
- busy  out  1  any slot full or any response outstanding.
- order_err  out  1  sticky response-order error.
- timeout_err  out  1  sticky timeout error.

Function
REQ-003 SHALL hold one request per core; c_ready[i] = slot i empty; capture on c_valid[i]&&c_ready[i].
REQ-004 SHALL drive req=1 when any slot is full and the tag FIFO is not full; req, core_id, opcode, addr, A, B and we SHALL be combinational from the selected slot.
REQ-005 Selection SHALL be round-robin: lowest full slot at or after rr_ptr, wrapping 3->0; rr_ptr resets to 0.
REQ-006 Issue SHALL occur on a cycle with req&&gnt: the slot clears, rr_ptr becomes selected+1 mod 4, and core_id is pushed into the 4-deep tag FIFO.
REQ-007 A slot cleared by issue SHALL show c_ready=1 from the next cycle; there is no same-cycle refill.
REQ-008 On rvalid the tag FIFO SHALL pop; rsp_valid[core_id_out] and rsp_data lane core_id_out SHALL be registered, one cycle after rvalid, one-cycle pulse; other lanes SHALL hold 0.
REQ-009 rvalid with the FIFO empty, or with the head not equal to core_id_out, SHALL set order_err; the response is still routed by core_id_out; the pop is suppressed only when the FIFO is empty.
REQ-010 A simultaneous push and pop SHALL leave the occupancy unchanged, including when the FIFO is full; req stays gated by the full flag sampled before the pop.
REQ-011 busy SHALL equal (any slot full) || (FIFO occupancy != 0).
REQ-012 End-to-end latency SHALL be 3 cycles: issue at edge T, rvalid at edge T+2, rsp_valid at edge T+3.

Reset
REQ-013 On rst_n=0, asynchronously: slots empty, FIFO empty, rr_ptr=0, rsp_valid=0, rsp_data=0, order_err=0, timeout_err=0, timeout counter=0.
REQ-014 Reset mid-transaction SHALL discard held and outstanding requests; a later rvalid with an empty FIFO flags order_err per REQ-009.
REQ-015 order_err and timeout_err SHALL clear only on reset.

Configuration
REQ-016 Macro MP_REQ_TIMEOUT_EN, when defined: the counter clears on rvalid or when the FIFO is empty and otherwise increments; on reaching TIMEOUT it sets timeout_err, flushes the FIFO and clears.
REQ-017 Without MP_REQ_TIMEOUT_EN: no counter exists, timeout_err is tied to 0, and the FIFO only drains on rvalid.

Verification
REQ-018 Core 2, opcode 0001, A=5, B=3 -> req for one cycle with core_id=2; rsp_valid[2] 3 cycles after issue with data 8.
REQ-019 All four c_valid high on the same cycle after reset, gnt=1 -> issue order 0,1,2,3 on consecutive cycles; rsp_valid pulses in the same order.
REQ-020 Core 1 STORE (opcode 0110) addr=0x10, A=0xAA, then core 1 LOAD (opcode 0101) addr=0x10 -> responses 0xAA and 0xAA on lane 1; order_err=0.
REQ-021 Core 1 issued, then rvalid forced with core_id_out=3 -> rsp_valid[3]=1 and order_err=1 until reset.
REQ-022 With MP_REQ_TIMEOUT_EN and TIMEOUT=16, issue with rvalid held at 0 -> timeout_err=1 after 16 cycles and busy=0; without the macro, timeout_err stays 0 and busy stays 1.
REQ-023 rst_n pulsed low with 2 responses outstanding -> all outputs take their reset values immediately; c_ready=4'b1111.
